// File: rtl/fsk_symbol_sched.sv
// fsk_symbol_sched: drains a 513-bit frame buffer (bit 512 = full flag) as 128 4-bit 16FSK symbols.
// Optional macro FSK_PREAMBLE_EN: emit preamble symbols F,0,F,0 ahead of each frame's payload.
module fsk_symbol_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  output logic [9:0]  add_rom,
  input  logic        read_rom,
  output logic        web,
  output logic        write_rom,
  output logic [3:0]  sym_out,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam logic [9:0] FLAG_ADDR = 10'd512;
  localparam logic [9:0] LAST_IDX  = 10'd508;

  typedef enum logic [2:0] {
    IDLE,
    POLL_A,
    POLL_W,
`ifdef FSK_PREAMBLE_EN
    PRE,
`endif
    FETCH,
    HOLD,
    RELEASE
  } state_t;

  state_t      state_reg;
  logic [9:0]  bit_idx_reg;
  logic [2:0]  fetch_cnt_reg;
  logic [2:0]  shift_reg;
`ifdef FSK_PREAMBLE_EN
  logic [1:0]  pre_cnt_reg;
  logic        in_pre_reg;
`endif

  // The buffer is only ever written to clear the flag, so the data bit is fixed.
  assign write_rom = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      add_rom       <= '0;
      web           <= 1'b0;
      sym_out       <= '0;
      sym_valid     <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      busy          <= 1'b0;
      bit_idx_reg   <= '0;
      fetch_cnt_reg <= '0;
      shift_reg     <= '0;
`ifdef FSK_PREAMBLE_EN
      pre_cnt_reg   <= '0;
      in_pre_reg    <= 1'b0;
`endif
    end else if (!En) begin
      // Abandon the frame in place: the flag is left set so the frame is resent.
      state_reg     <= IDLE;
      add_rom       <= '0;
      web           <= 1'b0;
      sym_out       <= '0;
      sym_valid     <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      bit_idx_reg   <= '0;
      fetch_cnt_reg <= '0;
`ifdef FSK_PREAMBLE_EN
      pre_cnt_reg   <= '0;
      in_pre_reg    <= 1'b0;
`endif
    end else begin
      web        <= 1'b0;
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          state_reg <= POLL_A;
          add_rom   <= FLAG_ADDR;
        end
        POLL_A: state_reg <= POLL_W;
        POLL_W: begin
          if (read_rom) begin
            bit_idx_reg <= '0;
            busy        <= 1'b1;
`ifdef FSK_PREAMBLE_EN
            state_reg   <= PRE;
            pre_cnt_reg <= '0;
            in_pre_reg  <= 1'b1;
`else
            state_reg     <= FETCH;
            add_rom       <= '0;
            fetch_cnt_reg <= '0;
`endif
          end else begin
            state_reg <= POLL_A;
          end
        end
`ifdef FSK_PREAMBLE_EN
        PRE: begin
          sym_out   <= pre_cnt_reg[0] ? 4'h0 : 4'hF;
          sym_valid <= 1'b1;
          state_reg <= HOLD;
        end
`endif
        FETCH: begin
          // Addresses lead the returning read data by one cycle.
          fetch_cnt_reg <= fetch_cnt_reg + 3'd1;
          if (fetch_cnt_reg < 3'd3)
            add_rom <= bit_idx_reg + {7'd0, fetch_cnt_reg} + 10'd1;
          if (fetch_cnt_reg != 3'd0)
            shift_reg <= {shift_reg[1:0], read_rom};
          if (fetch_cnt_reg == 3'd4) begin
            sym_out   <= {shift_reg, read_rom};
            sym_valid <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (sym_ready) begin
            sym_valid <= 1'b0;
`ifdef FSK_PREAMBLE_EN
            if (in_pre_reg) begin
              if (pre_cnt_reg == 2'd3) begin
                in_pre_reg    <= 1'b0;
                state_reg     <= FETCH;
                add_rom       <= bit_idx_reg;
                fetch_cnt_reg <= '0;
              end else begin
                pre_cnt_reg <= pre_cnt_reg + 2'd1;
                state_reg   <= PRE;
              end
            end else
`endif
            begin
              bit_idx_reg <= bit_idx_reg + 10'd4;
              if (bit_idx_reg == LAST_IDX) begin
                state_reg <= RELEASE;
                add_rom   <= FLAG_ADDR;
                web       <= 1'b1;
              end else begin
                state_reg     <= FETCH;
                add_rom       <= bit_idx_reg + 10'd4;
                fetch_cnt_reg <= '0;
              end
            end
          end
        end
        RELEASE: begin
          state_reg  <= POLL_A;
          add_rom    <= FLAG_ADDR;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
          busy       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_symbol_sched.sv
// Testbench for fsk_symbol_sched: frame buffer model plus a symbol-list reference per frame.
// Honours FSK_PREAMBLE_EN when defined for the build.
module tb_fsk_symbol_sched;

  logic        clk = 1'b0;
  logic        rst, En, read_rom, web, write_rom, sym_valid, sym_ready, frame_done, busy;
  logic [9:0]  add_rom;
  logic [3:0]  sym_out;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  bit   payload [0:511];
  logic flag = 1'b0;
  logic set_flag = 1'b0;

`ifdef FSK_PREAMBLE_EN
  localparam int NPRE = 4;
`else
  localparam int NPRE = 0;
`endif
  localparam int TOTAL = 128 + NPRE;

  always #5 clk = ~clk;

  // Frame buffer port B: synchronous read, only the flag bit is writable.
  always @(posedge clk) begin
    if (add_rom == 10'd512)     read_rom <= flag;
    else if (add_rom < 10'd512) read_rom <= payload[add_rom[8:0]];
    else                        read_rom <= 1'b0;
    if (web && add_rom == 10'd512) flag <= write_rom;
    else if (set_flag)             flag <= 1'b1;
  end

  fsk_symbol_sched dut (
    .clk(clk), .rst(rst), .En(En), .add_rom(add_rom), .read_rom(read_rom),
    .web(web), .write_rom(write_rom), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  // mode 0: ready tied high, 1: random ready, 2: 10-cycle stall on the first 3 symbols.
  task automatic do_frame(input int mode, input bit reload, input bit force_b, input int stop_after);
    logic [3:0] expq[$];
    logic [3:0] s;
    logic [3:0] prev_sym = '0;
    int  xfers = 0, cyc = 0, web_cyc = -10, age = -1, base = 0, stall = 0;
    bit  pending = 0, prev_hold = 0, first_busy = 0, finished = 0, stopped = 0;
    if (reload) begin
      for (int i = 0; i < 512; i++) payload[i] = 1'($urandom_range(0, 1));
      if (force_b) begin
        payload[0] = 1; payload[1] = 0; payload[2] = 1; payload[3] = 1;
      end
    end
    for (int p = 0; p < NPRE; p++) expq.push_back((p % 2 == 0) ? 4'hF : 4'h0);
    for (int k = 0; k < 128; k++) begin
      s = {payload[4*k], payload[4*k+1], payload[4*k+2], payload[4*k+3]};
      expq.push_back(s);
    end
    set_flag = 1'b1; En = 1'b1; sym_ready = 1'b0;
    @(negedge clk);
    set_flag = 1'b0;
    while (!finished && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (web !== 1'b0) begin
        checks++;
        if (xfers != TOTAL || add_rom !== 10'd512 || write_rom !== 1'b0 || web_cyc >= 0) begin
          errors++;
          $display("FAIL web_release: web=%b add_rom=%0d write_rom=%b after %0d xfers, required web only once after %0d xfers at 512 with 0",
                   web, add_rom, write_rom, xfers, TOTAL);
        end
        web_cyc = cyc;
      end
      if (web_cyc >= 0 && cyc == web_cyc + 1) begin
        checks++;
        if (frame_done !== 1'b1) begin
          errors++; $display("FAIL frame_done_pulse: got %b required 1", frame_done);
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames + 1)) begin
          errors++; $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, exp_frames + 1);
        end
        exp_frames++;
        finished = 1;
      end else begin
        checks++;
        if (frame_done !== 1'b0) begin
          errors++; $display("FAIL frame_done_spurious: got %b required 0 at cycle %0d", frame_done, cyc);
        end
      end
      if (prev_hold) begin
        checks++;
        if (sym_valid !== 1'b1 || sym_out !== prev_sym) begin
          errors++;
          $display("FAIL hold_stable: valid=%b sym=%h required valid=1 sym=%h", sym_valid, sym_out, prev_sym);
        end
      end
      if (pending) begin
        age = 0; pending = 0;
      end else if (!first_busy && busy === 1'b1) begin
        first_busy = 1;
        if (NPRE == 0 && xfers == 0) begin age = 0; base = 0; end
      end
      if (age >= 0) begin
        if (age < 4) begin
          checks++;
          if (add_rom !== 10'(base + age)) begin
            errors++; $display("FAIL fetch_addr: got %0d required %0d", add_rom, base + age);
          end
        end
        if (age < 5) begin
          checks++;
          if (sym_valid !== 1'b0) begin
            errors++; $display("FAIL early_valid: sym_valid=%b at fetch cycle %0d, required 0", sym_valid, age);
          end
          age++;
        end else begin
          checks++;
          if (sym_valid !== 1'b1) begin
            errors++; $display("FAIL valid_latency: sym_valid=%b 5 cycles after fetch of bit %0d, required 1", sym_valid, base);
          end
          age = -1;
        end
      end
      case (mode)
        0: sym_ready = 1'b1;
        1: sym_ready = 1'($urandom_range(0, 1));
        default: begin
          if (sym_valid === 1'b1 && xfers < 3 && stall < 10) begin
            sym_ready = 1'b0; stall++;
          end else begin
            sym_ready = 1'b1;
            if (sym_valid === 1'b1) stall = 0;
          end
        end
      endcase
      prev_hold = (sym_valid === 1'b1) && !sym_ready;
      prev_sym  = sym_out;
      if (sym_valid === 1'b1 && sym_ready) begin
        checks++;
        if (xfers >= TOTAL) begin
          errors++; $display("FAIL extra_symbol: symbol %h beyond %0d per frame", sym_out, TOTAL);
        end else if (sym_out !== expq[xfers]) begin
          errors++; $display("FAIL symbol[%0d]: got %h required %h", xfers, sym_out, expq[xfers]);
        end else begin
          $display("xfer frame=%0d idx=%0d sym=%h", exp_frames, xfers, sym_out);
        end
        xfers++;
        if (xfers >= NPRE && xfers < TOTAL) begin
          pending = 1; base = 4 * (xfers - NPRE);
        end
        if (stop_after > 0 && xfers == stop_after) begin
          stopped = 1; finished = 1;
        end
      end
    end
    if (!stopped) begin
      checks++;
      if (!finished) begin
        errors++; $display("FAIL frame_timeout: %0d transfers seen, required %0d then release", xfers, TOTAL);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; En = 1'b1; sym_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (add_rom !== 10'd0)   begin errors++; $display("FAIL reset_add_rom: got %0d required 0", add_rom); end
    checks++; if (web !== 1'b0)        begin errors++; $display("FAIL reset_web: got %b required 0", web); end
    checks++; if (write_rom !== 1'b0)  begin errors++; $display("FAIL reset_write_rom: got %b required 0", write_rom); end
    checks++; if (sym_out !== 4'h0)    begin errors++; $display("FAIL reset_sym_out: got %h required 0", sym_out); end
    checks++; if (sym_valid !== 1'b0)  begin errors++; $display("FAIL reset_sym_valid: got %b required 0", sym_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    En = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (add_rom !== 10'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_disabled: add_rom=%0d busy=%b required 0/0", add_rom, busy);
    end
  endtask

  task automatic test_poll_empty;
    int seen512 = 0;
    En = 1'b1; sym_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (web !== 1'b0 || sym_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL poll_quiet: web=%b sym_valid=%b busy=%b required 0/0/0", web, sym_valid, busy);
      end
      if (add_rom === 10'd512) seen512++;
    end
    checks++;
    if (seen512 < 10) begin
      errors++; $display("FAIL poll_addr: add_rom=512 on %0d of 20 cycles, required at least 10", seen512);
    end
  endtask

  task automatic test_first_symbol;
    do_frame(0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random_ready;
    do_frame(1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_hold_stall;
    do_frame(2, 1'b1, 1'b0, 0);
  endtask

  task automatic test_en_drop;
    do_frame(0, 1'b1, 1'b0, 50 + NPRE);
    @(negedge clk);
    En = 1'b0;
    @(negedge clk);
    checks++;
    if (sym_valid !== 1'b0 || busy !== 1'b0 || add_rom !== 10'd0) begin
      errors++; $display("FAIL en_drop_idle: sym_valid=%b busy=%b add_rom=%0d required 0/0/0", sym_valid, busy, add_rom);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (web !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
        errors++; $display("FAIL en_drop_hold: web=%b frame_cnt=%0d required 0/%0d", web, frame_cnt, exp_frames);
      end
    end
    checks++;
    if (flag !== 1'b1) begin
      errors++; $display("FAIL en_drop_flag: flag=%b required 1", flag);
    end
    do_frame(0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_midframe;
    do_frame(1, 1'b1, 1'b0, 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sym_valid !== 1'b0 || busy !== 1'b0 || web !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_midframe: sym_valid=%b busy=%b web=%b frame_cnt=%0d required 0/0/0/0",
               sym_valid, busy, web, frame_cnt);
    end
    checks++;
    if (flag !== 1'b1) begin
      errors++; $display("FAIL reset_midframe_flag: flag=%b required 1", flag);
    end
    exp_frames = 0;
    rst = 1'b0;
    do_frame(0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1; En = 1'b0; sym_ready = 1'b0;
    test_reset();
    test_poll_empty();
    test_first_symbol();
    test_random_ready();
    test_hold_stall();
    test_en_drop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
